// File: rtl/param_seq_fsm_pkg.sv
// Shared state encoding and command codes for the step sequencer.
// State codes 5..7 are unused and treated as corruption by the sequencer.
package param_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

endpackage

// File: rtl/param_seq_fsm_if.sv
// Host command handshake plus step/status outputs of the sequencer.
// Commands transfer on cmd_valid && cmd_ready; status signals are level outputs.
interface param_seq_fsm_if #(
  parameter int STEP_W = 2
);

  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cmd_ready;
  logic              err_clr;
  logic [STEP_W-1:0] out;
  logic              step_stb;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd, err_clr,
    input  cmd_ready, out, step_stb, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd, err_clr,
    output cmd_ready, out, step_stb, busy, done, err
  );

endinterface

// File: rtl/param_seq_fsm_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, expire is combinational (0 cycles).
// No backpressure; clear has priority over enable, holding enable low freezes the count.
module seq_dwell_cnt #(
  parameter int DWELL   = 3,
  parameter int DWELL_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [DWELL_W-1:0] r_count;
  logic               w_at_last;

  assign w_at_last = (r_count == DWELL_W'(DWELL - 1));
  assign o_expire  = i_enable && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_last ? '0 : r_count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/param_seq_fsm.sv
// Command-driven step sequencer: out advances every DWELL running cycles, 1-cycle command latency.
// cmd_ready drops only in FAULT; corrupt state or step codes force FAULT until err_clr.
module param_seq_fsm
  import param_seq_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int DWELL     = 3,
  parameter int DWELL_W   = 4,
  parameter int WRAP      = 0
) (
  input  logic               clk,
  input  logic               rst,
  param_seq_fsm_if.slave     bus
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_e            r_state, w_nxt_state;
  logic [STEP_W-1:0] r_out, w_nxt_out;
  logic              r_stb, w_nxt_stb;
  logic              r_err, w_nxt_err;

  logic w_acc, w_start, w_pause, w_abort;
  logic w_illegal, w_cnt_en, w_cnt_clr, w_expire;

  assign bus.cmd_ready = (r_state == IDLE) || (r_state == RUN) ||
                         (r_state == PAUSE) || (r_state == DONE);
  assign w_acc   = bus.cmd_valid && bus.cmd_ready;
  assign w_start = w_acc && (bus.cmd == CMD_START);
  assign w_pause = w_acc && (bus.cmd == CMD_PAUSE);
  assign w_abort = w_acc && (bus.cmd == CMD_ABORT);

  // Widened compare keeps the out-of-range check meaningful for any NUM_STEPS.
  assign w_illegal = (r_state > FAULT) || (32'(r_out) >= 32'(NUM_STEPS));

  // An accepted PAUSE/ABORT beats a coincident dwell expiry, so the counter sees no tick.
  assign w_cnt_en = (r_state == RUN) && !w_illegal && !w_pause && !w_abort;

  seq_dwell_cnt #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_out   = r_out;
    w_nxt_stb   = 1'b0;
    w_nxt_err   = r_err;
    w_cnt_clr   = 1'b0;
    if (w_illegal) begin
      w_nxt_state = FAULT;
      w_nxt_out   = '0;
      w_nxt_err   = 1'b1;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_nxt_state = RUN;
            w_nxt_out   = '0;
            w_cnt_clr   = 1'b1;
          end
        end
        RUN: begin
          if (w_abort) begin
            w_nxt_state = IDLE;
            w_nxt_out   = '0;
            w_cnt_clr   = 1'b1;
          end else if (w_pause) begin
            w_nxt_state = PAUSE;
          end else if (w_expire) begin
            if (r_out != LAST_STEP) begin
              w_nxt_out = r_out + STEP_W'(1);
              w_nxt_stb = 1'b1;
            end else if (WRAP != 0) begin
              w_nxt_out = '0;
              w_nxt_stb = 1'b1;
            end else begin
              w_nxt_state = DONE;
            end
          end
        end
        PAUSE: begin
          if (w_abort) begin
            w_nxt_state = IDLE;
            w_nxt_out   = '0;
            w_cnt_clr   = 1'b1;
          end else if (w_start) begin
            w_nxt_state = RUN;
          end
        end
        DONE: begin
          if (w_abort) begin
            w_nxt_state = IDLE;
            w_nxt_out   = '0;
            w_cnt_clr   = 1'b1;
          end else if (w_start) begin
            w_nxt_state = RUN;
            w_nxt_out   = '0;
            w_cnt_clr   = 1'b1;
          end
        end
        FAULT: begin
          w_nxt_out = '0;
          w_cnt_clr = 1'b1;
          if (bus.err_clr) begin
            w_nxt_state = IDLE;
            w_nxt_err   = 1'b0;
          end
        end
        default: begin
          w_nxt_state = FAULT;
          w_nxt_out   = '0;
          w_nxt_err   = 1'b1;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_out   <= w_nxt_out;
      r_stb   <= w_nxt_stb;
      r_err   <= w_nxt_err;
    end
  end

  assign bus.out      = r_out;
  assign bus.step_stb = r_stb;
  assign bus.busy     = (r_state == RUN) || (r_state == PAUSE);
  assign bus.done     = (r_state == DONE);
  assign bus.err      = r_err;

endmodule

// File: tb/tb_param_seq_fsm.sv
// Directed bench for param_seq_fsm: three parameter sets driven in one linear sequence.
// Expected values are hand-derived cycle numbers from the START-accepting edge.
module tb_param_seq_fsm;
  import param_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  param_seq_fsm_if #(.STEP_W(2)) if0 ();
  param_seq_fsm_if #(.STEP_W(3)) if1 ();
  param_seq_fsm_if #(.STEP_W(1)) if2 ();

  param_seq_fsm #(.NUM_STEPS(4), .DWELL(3), .DWELL_W(4), .WRAP(0)) u0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  param_seq_fsm #(.NUM_STEPS(5), .DWELL(2), .DWELL_W(4), .WRAP(1)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  param_seq_fsm #(.NUM_STEPS(2), .DWELL(1), .DWELL_W(4), .WRAP(1)) u2 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst = 1'b1;
    if0.cmd_valid = 1'b0; if0.cmd = CMD_NOP; if0.err_clr = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd = CMD_NOP; if1.err_clr = 1'b0;
    if2.cmd_valid = 1'b0; if2.cmd = CMD_NOP; if2.err_clr = 1'b0;
    #3;
    chk("rst_out",   32'(if0.out), 32'd0);
    chk("rst_busy",  32'(if0.busy), 32'd0);
    chk("rst_done",  32'(if0.done), 32'd0);
    chk("rst_err",   32'(if0.err), 32'd0);
    chk("rst_stb",   32'(if0.step_stb), 32'd0);
    chk("rst_ready", 32'(if0.cmd_ready), 32'd1);
    #9 rst = 1'b0;
    tick();

    // Plan 1: defaults, out=0,1,2,3 at cycles 1,4,7,10; DONE from 13
    if0.cmd_valid = 1'b1; if0.cmd = CMD_START;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) if0.cmd_valid = 1'b0;
      chk($sformatf("t1_out_c%0d", c), 32'(if0.out),
          (c >= 10) ? 32'd3 : (c >= 7) ? 32'd2 : (c >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t1_stb_c%0d", c), 32'(if0.step_stb),
          (c == 4 || c == 7 || c == 10) ? 32'd1 : 32'd0);
      chk($sformatf("t1_done_c%0d", c), 32'(if0.done), (c >= 13) ? 32'd1 : 32'd0);
      chk($sformatf("t1_busy_c%0d", c), 32'(if0.busy), (c >= 13) ? 32'd0 : 32'd1);
    end

    // Plan 3: restart from DONE, pause at count 1 of step 2, resume, abort on expiry
    if0.cmd_valid = 1'b1; if0.cmd = CMD_START;
    tick();
    if0.cmd_valid = 1'b0;
    chk("t3_restart_out", 32'(if0.out), 32'd0);
    chk("t3_restart_done", 32'(if0.done), 32'd0);
    for (int c = 2; c <= 8; c++) tick();
    chk("t3_c8_out", 32'(if0.out), 32'd2);
    if0.cmd_valid = 1'b1; if0.cmd = CMD_PAUSE;
    tick();
    if0.cmd_valid = 1'b0;
    chk("t3_pause_state", 32'(u0.r_state), 32'(PAUSE));
    for (int c = 9; c <= 13; c++) begin
      if (c > 9) tick();
      chk($sformatf("t3_hold_out_c%0d", c), 32'(if0.out), 32'd2);
      chk($sformatf("t3_hold_stb_c%0d", c), 32'(if0.step_stb), 32'd0);
      chk($sformatf("t3_hold_busy_c%0d", c), 32'(if0.busy), 32'd1);
    end
    if0.cmd_valid = 1'b1; if0.cmd = CMD_START;
    tick();
    if0.cmd_valid = 1'b0;
    chk("t3_c14_out", 32'(if0.out), 32'd2);
    chk("t3_c14_state", 32'(u0.r_state), 32'(RUN));
    tick();
    chk("t3_c15_out", 32'(if0.out), 32'd2);
    tick();
    chk("t3_c16_out", 32'(if0.out), 32'd3);
    chk("t3_c16_stb", 32'(if0.step_stb), 32'd1);
    tick();
    tick();
    if0.cmd_valid = 1'b1; if0.cmd = CMD_ABORT;
    tick();
    if0.cmd_valid = 1'b0;
    chk("t3_abort_state", 32'(u0.r_state), 32'(IDLE));
    chk("t3_abort_out", 32'(if0.out), 32'd0);
    chk("t3_abort_stb", 32'(if0.step_stb), 32'd0);
    chk("t3_abort_done", 32'(if0.done), 32'd0);

    // Plan 2: NUM_STEPS=5 DWELL=2 WRAP=1
    if1.cmd_valid = 1'b1; if1.cmd = CMD_START;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) if1.cmd_valid = 1'b0;
      chk($sformatf("t2_out_c%0d", c), 32'(if1.out), 32'(((c - 1) / 2) % 5));
      chk($sformatf("t2_stb_c%0d", c), 32'(if1.step_stb),
          (c >= 3 && (c % 2) == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t2_done_c%0d", c), 32'(if1.done), 32'd0);
    end

    // Plan 4: out=6 is out of range for 5 steps
    force u1.r_out = 3'd6;
    #1;
    release u1.r_out;
    tick();
    chk("t4_fault_state", 32'(u1.r_state), 32'(FAULT));
    chk("t4_fault_err", 32'(if1.err), 32'd1);
    chk("t4_fault_out", 32'(if1.out), 32'd0);
    chk("t4_fault_ready", 32'(if1.cmd_ready), 32'd0);
    if1.cmd_valid = 1'b1; if1.cmd = CMD_START;
    tick();
    tick();
    if1.cmd_valid = 1'b0;
    chk("t4_start_ignored", 32'(u1.r_state), 32'(FAULT));
    chk("t4_start_busy", 32'(if1.busy), 32'd0);
    chk("t4_sticky_err", 32'(if1.err), 32'd1);
    if1.err_clr = 1'b1;
    tick();
    if1.err_clr = 1'b0;
    chk("t4_clr_state", 32'(u1.r_state), 32'(IDLE));
    chk("t4_clr_err", 32'(if1.err), 32'd0);
    chk("t4_clr_ready", 32'(if1.cmd_ready), 32'd1);

    // Plan 5: illegal state code, then async reset mid-RUN
    force u0.r_state = state_e'(3'd7);
    #1;
    release u0.r_state;
    tick();
    chk("t5_fault_state", 32'(u0.r_state), 32'(FAULT));
    chk("t5_fault_err", 32'(if0.err), 32'd1);
    chk("t5_fault_ready", 32'(if0.cmd_ready), 32'd0);
    if0.err_clr = 1'b1;
    tick();
    if0.err_clr = 1'b0;
    chk("t5_clr_state", 32'(u0.r_state), 32'(IDLE));
    if0.err_clr = 1'b1;
    tick();
    if0.err_clr = 1'b0;
    chk("t5_clr_ignored", 32'(u0.r_state), 32'(IDLE));
    if0.cmd_valid = 1'b1; if0.cmd = CMD_START;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) if0.cmd_valid = 1'b0;
    end
    chk("t5_pre_out", 32'(if0.out), 32'd1);
    chk("t5_pre_stb", 32'(if0.step_stb), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_out", 32'(if0.out), 32'd0);
    chk("t5_rst_stb", 32'(if0.step_stb), 32'd0);
    chk("t5_rst_busy", 32'(if0.busy), 32'd0);
    chk("t5_rst_done", 32'(if0.done), 32'd0);
    chk("t5_rst_err", 32'(if0.err), 32'd0);
    chk("t5_rst_ready", 32'(if0.cmd_ready), 32'd1);
    #2 rst = 1'b0;
    tick();
    chk("t5_post_state", 32'(u0.r_state), 32'(IDLE));

    // Plan 6: DWELL=1, 2 steps, wrap
    if2.cmd_valid = 1'b1; if2.cmd = CMD_START;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) if2.cmd_valid = 1'b0;
      chk($sformatf("t6_out_c%0d", c), 32'(if2.out), 32'((c - 1) % 2));
      chk($sformatf("t6_stb_c%0d", c), 32'(if2.step_stb), (c >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("t6_busy_c%0d", c), 32'(if2.busy), 32'd1);
    end
    if2.cmd_valid = 1'b1; if2.cmd = CMD_ABORT;
    tick();
    if2.cmd_valid = 1'b0;
    chk("t6_abort_out", 32'(if2.out), 32'd0);
    chk("t6_abort_stb", 32'(if2.step_stb), 32'd0);
    chk("t6_abort_busy", 32'(if2.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/param_seq_fsm.md
Name: param_seq_fsm

Overview:
Parametrised command-driven step sequencer, the next generation of the team's small cyclic FSMs. It walks a step index 0..NUM_STEPS-1, holding each step for DWELL cycles. It can optionally wrap back to step 0 and accepts start, pause and abort commands over a valid/ready handshake. Illegal state or step encodings are detected and recovered to a defined FAULT state, never left undefined. It sits between a host command source and downstream logic that decodes the step index.

Parameters:
NUM_STEPS, 4, number of steps; legal range 2..16.
DWELL, 3, cycles spent in each step while running; legal range 1..2**DWELL_W-1.
DWELL_W, 4, width of the dwell counter.
WRAP, 0, 1 = after the last step return to step 0 and keep running; 0 = stop in DONE.
STEP_W, derived localparam, $clog2(NUM_STEPS); not overridable.

Ports:
clk  input  1  single clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd  input  2  command code: 00 NOP, 01 START, 10 PAUSE, 11 ABORT.
cmd_ready  output  1  command can be accepted this cycle.
err_clr  input  1  clears a fault; only acts in FAULT.
out  output  STEP_W  current step index, registered.
step_stb  output  1  one-cycle pulse when out changes by advance or wrap.
busy  output  1  high in RUN or PAUSE.
done  output  1  level, high in DONE.
err  output  1  sticky fault flag.

Behaviour:
- Reset (async, rst=1): state IDLE, out=0, dwell count=0, step_stb=0, busy=0, done=0, err=0. cmd_ready=1 once state is IDLE.
- States use a 3-bit encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3, FAULT=4. Codes 5..7 are illegal.
- cmd_ready=1 in IDLE, RUN, PAUSE and DONE; 0 in FAULT. A command is accepted when cmd_valid && cmd_ready. All effects are visible the cycle after the accepting edge.
- IDLE: START -> RUN with out=0 and count=0. PAUSE, ABORT and NOP are ignored.
- RUN: count increments every cycle.
- RUN, count==DWELL-1, out<NUM_STEPS-1: out increments, count returns to 0, step_stb pulses.
- RUN, count==DWELL-1, out==NUM_STEPS-1, WRAP=1: out returns to 0, stay in RUN, step_stb pulses.
- RUN, count==DWELL-1, out==NUM_STEPS-1, WRAP=0: go to DONE, out holds at NUM_STEPS-1, no step_stb.
- RUN commands: PAUSE -> PAUSE with count and out frozen. ABORT -> IDLE with out=0 and count=0. START is ignored.
- PAUSE: START -> RUN, resuming from the frozen count. ABORT -> IDLE. PAUSE is ignored.
- DONE: START -> RUN from step 0. ABORT -> IDLE.
- Simultaneous command and dwell expiry: the accepted command wins. PAUSE freezes without advancing; ABORT goes to IDLE. No step_stb is issued in that cycle.
- Illegal detection, checked every cycle: a state code in 5..7, or out>=NUM_STEPS (possible when NUM_STEPS is not a power of 2). Either condition sends the FSM to FAULT on the next edge with err=1, out=0, count=0 and all commands blocked.
- FAULT: err_clr=1 -> IDLE on the next edge with err=0. Without err_clr, FAULT holds indefinitely. err_clr in any other state is ignored.
- Reset asserted mid-operation (RUN, PAUSE or FAULT) returns immediately to the reset values, independent of clk.
- The dwell counter never exceeds DWELL-1. With DWELL=1 the step advances every running cycle.
- Sequencing uses no latches and no combinational loops. The next-state logic has a default branch that targets FAULT.

Decomposition:
- Package param_seq_pkg holds:
  - the state localparams IDLE, RUN, PAUSE, DONE, FAULT and the state width of 3;
  - the command codes CMD_NOP, CMD_START, CMD_PAUSE, CMD_ABORT.
- One sub-module, seq_dwell_cnt, parametrised on DWELL and DWELL_W:
  - inputs: clear, enable;
  - output: expire, asserted when count==DWELL-1 && enable.
- The top module contains the state register, the step register, illegal-state detection and the handshake.

Test Plan:
1. Defaults (NUM_STEPS=4, DWELL=3, WRAP=0): reset, then START accepted at cycle 0. Required: out=0,1,2,3 at cycles 1,4,7,10; done=1 from cycle 13; step_stb pulses at cycles 4, 7 and 10 only.
2. WRAP=1, NUM_STEPS=5, DWELL=2: START. Required: out sequence 0,1,2,3,4,0 with a transition every 2 cycles, and done never asserted.
3. PAUSE at count==1 of step 2, held 5 cycles, then START. Required: out stays 2 throughout the pause and advances to 3 two cycles after resume (the remaining dwell). ABORT issued on the same cycle as dwell expiry: required IDLE, out=0, no step_stb.
4. NUM_STEPS=5: force out=6 via the bench, release. Required: the next edge gives FAULT, err=1, out=0, cmd_ready=0; START is ignored. err_clr for 1 cycle gives IDLE and err=0.
5. Force the state code to 7. Required: FAULT on the next edge. Assert rst mid-RUN between clock edges. Required: all outputs go to reset values immediately and cmd_ready=1.
6. DWELL=1, NUM_STEPS=2, WRAP=1: START. Required: out toggles 0,1,0,1 every cycle, with step_stb high on every running cycle.
